// File: rtl/ws281x_rx.sv
// WS281x single-wire NRZ receiver: measures high-pulse widths, decodes bits and
// assembles 24-bit GRB pixels (MSB first) onto a valid/ready stream.
module ws281x_rx #(
  parameter int unsigned SysClkFreq    = 30_000_000,
  parameter int unsigned MinHighCycles = 3,
  parameter int unsigned ThreshCycles  = 18,
  parameter int unsigned MaxHighCycles = 36,
  parameter int unsigned ResetCycles   = 1500,
  parameter int unsigned CntW          = $clog2(ResetCycles + 1)
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        enable_i,
  input  logic        ws281x_din_i,
  output logic [23:0] data_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic        data_first_o,
  output logic        idle_o,
  output logic        bit_err_o,
  output logic        overflow_o
);

  localparam int unsigned PixW    = 24;
  localparam int unsigned BitCntW = $clog2(PixW + 1);

  typedef enum logic [1:0] {StSync, StIdle, StHigh, StLow} state_e;

  // Pulse classification only makes sense for ordered thresholds.
  if (SysClkFreq == 0 || MinHighCycles >= ThreshCycles || ThreshCycles > MaxHighCycles ||
      MaxHighCycles >= ResetCycles) begin : g_param_check
    $error("ws281x_rx: inconsistent timing parameters");
  end

  state_e               state_q, state_d;
  logic                 din_s1_q, din_s2_q, din_prev_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitCntW-1:0]   bitcnt_q, bitcnt_d;
  logic [PixW-1:0]      shift_q, shift_d;
  logic [PixW-1:0]      data_q, data_d;
  logic                 first_q, first_d;
  logic                 valid_q, valid_d;
  logic                 dfirst_q, dfirst_d;
  logic                 idle_q, idle_d;
  logic                 bit_err_q, bit_err_d;
  logic                 ovf_q, ovf_d;
  logic                 rise, fall, bit_val, pix_done;

  always_comb begin
    rise      = din_s2_q & ~din_prev_q;
    fall      = ~din_s2_q & din_prev_q;
    bit_val   = (cnt_q >= CntW'(ThreshCycles));
    pix_done  = 1'b0;
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    first_d   = first_q;
    data_d    = data_q;
    dfirst_d  = dfirst_q;
    valid_d   = valid_q & ~data_ready_i;
    bit_err_d = 1'b0;
    ovf_d     = 1'b0;

    // Pulse width counter: restarts on every edge, saturates at all-ones.
    if (rise || fall) begin
      cnt_d = CntW'(1);
    end else if (cnt_q != {CntW{1'b1}}) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (!enable_i) begin
      state_d  = StSync;
      shift_d  = '0;
      bitcnt_d = '0;
      valid_d  = 1'b0;
    end else begin
      unique case (state_q)
        StSync: begin
          shift_d  = '0;
          bitcnt_d = '0;
          if (!din_s2_q && cnt_q >= CntW'(ResetCycles)) begin
            state_d = StIdle;
            first_d = 1'b1;
          end
        end
        StIdle: begin
          if (rise) state_d = StHigh;
        end
        StHigh: begin
          if (fall && cnt_q < CntW'(MinHighCycles)) begin
            bit_err_d = 1'b1;
            bitcnt_d  = '0;
            state_d   = StSync;
          end else if (cnt_q > CntW'(MaxHighCycles)) begin
            bit_err_d = 1'b1;
            state_d   = StSync;
          end else if (fall) begin
            // Bits land MSB first; position is indexed by the running bit count.
            shift_d[BitCntW'(PixW - 1) - bitcnt_q] = bit_val;
            state_d = StLow;
            if (bitcnt_q == BitCntW'(PixW - 1)) begin
              bitcnt_d = '0;
              pix_done = 1'b1;
            end else begin
              bitcnt_d = bitcnt_q + BitCntW'(1);
            end
          end
        end
        StLow: begin
          if (rise) begin
            state_d = StHigh;
          end else if (cnt_q >= CntW'(ResetCycles)) begin
            bit_err_d = (bitcnt_q != '0);
            bitcnt_d  = '0;
            shift_d   = '0;
            first_d   = 1'b1;
            state_d   = StIdle;
          end
        end
        default: state_d = StSync;
      endcase
    end

    // A completed pixel either lands in the output slot or is dropped.
    if (pix_done) begin
      first_d = 1'b0;
      if (!valid_q || data_ready_i) begin
        data_d   = shift_d;
        dfirst_d = first_q;
        valid_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    idle_d = (state_d == StIdle);
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      din_s1_q   <= 1'b0;
      din_s2_q   <= 1'b0;
      din_prev_q <= 1'b0;
      state_q    <= StSync;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      first_q    <= 1'b1;
      data_q     <= '0;
      dfirst_q   <= 1'b0;
      valid_q    <= 1'b0;
      idle_q     <= 1'b0;
      bit_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      din_s1_q   <= ws281x_din_i;
      din_s2_q   <= din_s1_q;
      din_prev_q <= din_s2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      first_q    <= first_d;
      data_q     <= data_d;
      dfirst_q   <= dfirst_d;
      valid_q    <= valid_d;
      idle_q     <= idle_d;
      bit_err_q  <= bit_err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign data_first_o = dfirst_q;
  assign idle_o       = idle_q;
  assign bit_err_o    = bit_err_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_ws281x_rx.sv
// Bench for ws281x_rx: pulse-level line model feeds a scoreboard of expected
// pixels; a monitor pops and compares on every accepted beat.
module tb_ws281x_rx;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic        enable_i;
  logic        ws281x_din_i;
  logic [23:0] data_o;
  logic        data_valid_o;
  logic        data_ready_i;
  logic        data_first_o;
  logic        idle_o;
  logic        bit_err_o;
  logic        overflow_o;

  ws281x_rx dut (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .enable_i     (enable_i),
    .ws281x_din_i (ws281x_din_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .data_first_o (data_first_o),
    .idle_o       (idle_o),
    .bit_err_o    (bit_err_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [23:0] data;
    logic        first;
    int          stamp;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          err_seen = 0, err_exp = 0;
  int          ovf_seen = 0, ovf_exp = 0;
  int          rdy_mode = 0;
  bit          hold_mode = 1'b0, slot_full = 1'b0;
  bit          m_synced = 1'b0, m_first = 1'b1;
  int          m_nbits = 0;
  logic [23:0] m_bits = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line model: a frame is a run of pulses between >=50us lows.
  function automatic void model_pulse(int h, int stamp);
    exp_t e;
    if (!m_synced) return;
    if (h < 3 || h > 36) begin
      err_exp++;
      m_synced = 1'b0;
      m_nbits  = 0;
      return;
    end
    m_bits = {m_bits[22:0], (h >= 18)};
    m_nbits++;
    if (m_nbits == 24) begin
      m_nbits = 0;
      e.data  = m_bits;
      e.first = m_first;
      e.stamp = stamp;
      m_first = 1'b0;
      if (hold_mode && slot_full) begin
        ovf_exp++;
      end else begin
        sb.push_back(e);
        if (hold_mode) slot_full = 1'b1;
      end
    end
  endfunction

  function automatic void model_gap();
    if (m_synced && m_nbits != 0) err_exp++;
    m_nbits  = 0;
    m_synced = 1'b1;
    m_first  = 1'b1;
  endfunction

  function automatic void model_reset();
    sb.delete();
    m_synced  = 1'b0;
    m_nbits   = 0;
    m_first   = 1'b1;
    slot_full = 1'b0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse(input int h, input int l);
    ws281x_din_i = 1'b1;
    tick(h);
    ws281x_din_i = 1'b0;
    model_pulse(h, cyc);
    tick(l);
  endtask

  task automatic gap();
    ws281x_din_i = 1'b0;
    tick(1600);
    model_gap();
  endtask

  // Sends the top n bits of px; fixed timing is T1H=24/T0H=12 in a 38-cycle bit.
  task automatic send_bits(input logic [23:0] px, input int n, input bit fixed);
    for (int i = 23; i > 23 - n; i--) begin
      int h;
      int l;
      if (fixed) begin
        h = px[i] ? 24 : 12;
        l = 38 - h;
      end else begin
        h = px[i] ? int'($urandom_range(36, 18)) : int'($urandom_range(17, 3));
        l = int'($urandom_range(60, 4));
      end
      pulse(h, l);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_sys);
      cyc++;
    end
  end

  initial begin
    data_ready_i = 1'b1;
    forever begin
      @(posedge clk_sys);
      #1;
      case (rdy_mode)
        0:       data_ready_i = 1'b1;
        1:       data_ready_i = ($urandom_range(3, 0) != 0);
        default: data_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: error/overflow pulse counting, latency, hold stability, beat compare.
  initial begin
    logic [23:0] d_prev;
    logic        v_prev, r_prev, f_prev;
    exp_t        e;
    d_prev = '0;
    v_prev = 1'b0;
    r_prev = 1'b0;
    f_prev = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (rst_sys_n) begin
        if (bit_err_o) err_seen++;
        if (overflow_o) ovf_seen++;
        if (data_valid_o && v_prev && !r_prev) begin
          chk("hold_data", data_o, d_prev);
          chk("hold_first", data_first_o, f_prev);
        end
        if (data_valid_o && !v_prev) begin
          if (sb.size() == 0) chk("unexpected_valid", data_valid_o, 0);
          else chk("latency", cyc - sb[0].stamp, 3);
        end
        if (data_valid_o && data_ready_i) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", data_valid_o, 0);
          end else begin
            e = sb.pop_front();
            chk("beat_data", data_o, e.data);
            chk("beat_first", data_first_o, e.first);
          end
        end
      end
      v_prev = data_valid_o;
      r_prev = data_ready_i;
      d_prev = data_o;
      f_prev = data_first_o;
    end
  end

  initial begin
    logic [23:0] px;
    rst_sys_n    = 1'b0;
    enable_i     = 1'b1;
    ws281x_din_i = 1'b0;
    tick(3);
    chk("rst_data", data_o, 0);
    chk("rst_valid", data_valid_o, 0);
    chk("rst_first", data_first_o, 0);
    chk("rst_idle", idle_o, 0);
    chk("rst_bit_err", bit_err_o, 0);
    chk("rst_overflow", overflow_o, 0);
    rst_sys_n = 1'b1;
    gap();
    chk("idle_after_gap", idle_o, 1);
    chk("valid_after_gap", data_valid_o, 0);

    // Nominal pixel.
    send_bits(24'hA5C30F, 24, 1'b1);
    tick(10);
    chk("sb_empty_nominal", sb.size(), 0);

    // Back-to-back pixels, then a fresh frame.
    send_bits(24'h000001, 24, 1'b1);
    send_bits(24'hFFFFFF, 24, 1'b1);
    send_bits(24'h800000, 24, 1'b1);
    gap();
    send_bits(24'h123456, 24, 1'b1);
    tick(10);
    chk("sb_empty_b2b", sb.size(), 0);

    // Consumer stalled across two pixels.
    gap();
    rdy_mode  = 2;
    hold_mode = 1'b1;
    slot_full = 1'b0;
    tick(2);
    send_bits(24'h111111, 24, 1'b1);
    send_bits(24'h222222, 24, 1'b1);
    tick(10);
    chk("ovf_count", ovf_seen, ovf_exp);
    chk("held_valid", data_valid_o, 1);
    chk("held_data", data_o, 24'h111111);
    rdy_mode  = 0;
    hold_mode = 1'b0;
    slot_full = 1'b0;
    tick(5);
    chk("sb_empty_hold", sb.size(), 0);

    // Glitch mid-pixel, then recovery only after a full gap.
    gap();
    px = 24'($urandom);
    send_bits(px, 10, 1'b0);
    pulse(2, 10);
    px = 24'($urandom);
    send_bits(px, 14, 1'b0);
    tick(10);
    chk("err_glitch", err_seen, err_exp);
    chk("sb_empty_glitch", sb.size(), 0);
    gap();
    send_bits(24'($urandom), 24, 1'b0);
    tick(10);
    chk("sb_empty_recover", sb.size(), 0);

    // Over-long high.
    gap();
    pulse(40, 20);
    gap();
    chk("err_overlong", err_seen, err_exp);

    // Partial pixel at frame end.
    send_bits(24'($urandom), 10, 1'b0);
    gap();
    chk("err_partial", err_seen, err_exp);
    chk("idle_partial", idle_o, 1);
    send_bits(24'($urandom), 24, 1'b0);
    tick(10);
    chk("sb_empty_partial", sb.size(), 0);

    // Width boundaries: 17 -> 0, 18 -> 1, 36 -> 1, 37 -> error.
    pulse(17, 10);
    pulse(18, 10);
    pulse(36, 10);
    send_bits(24'($urandom), 21, 1'b0);
    tick(10);
    chk("sb_empty_bounds", sb.size(), 0);
    pulse(37, 10);
    gap();
    chk("err_37", err_seen, err_exp);

    // Disable mid-pixel: no error, fresh frame afterwards.
    send_bits(24'($urandom), 10, 1'b0);
    enable_i = 1'b0;
    m_synced = 1'b0;
    m_nbits  = 0;
    tick(10);
    chk("idle_disabled", idle_o, 0);
    enable_i = 1'b1;
    gap();
    chk("err_disable", err_seen, err_exp);
    send_bits(24'($urandom), 24, 1'b0);
    tick(10);
    chk("sb_empty_enable", sb.size(), 0);

    // Reset while a pixel is held and another is half received.
    gap();
    rdy_mode  = 2;
    hold_mode = 1'b1;
    tick(2);
    send_bits(24'h5A5A5A, 24, 1'b1);
    send_bits(24'($urandom), 10, 1'b0);
    rst_sys_n = 1'b0;
    #1;
    chk("mid_rst_valid", data_valid_o, 0);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_first", data_first_o, 0);
    model_reset();
    hold_mode = 1'b0;
    rdy_mode  = 0;
    tick(3);
    rst_sys_n = 1'b1;
    gap();
    send_bits(24'($urandom), 24, 1'b0);
    tick(10);
    chk("sb_empty_reset", sb.size(), 0);

    // Randomised traffic with random backpressure.
    rdy_mode = 1;
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(3, 0) == 0) gap();
      send_bits(24'($urandom), 24, 1'b0);
    end
    tick(30);
    rdy_mode = 0;
    tick(5);

    chk("sb_empty_final", sb.size(), 0);
    chk("err_final", err_seen, err_exp);
    chk("ovf_final", ovf_seen, ovf_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
